// File: rtl/alu_pkg.sv
// Shared ALU control definitions: aluop codes, MIPS opcode/funct constants,
// default multi-cycle latencies and the decoded control-word layout.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_MULT = 4'b1100;
  localparam logic [3:0] ALU_DIV  = 4'b1101;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 32;

  typedef struct packed {
    logic [3:0] aluop;
    logic       use_imm;
    logic       imm_zext;
    logic       use_shamt;
    logic       multi;
    logic       illegal;
  } ctrl_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS opcode/funct decoder producing the ALU control word.
// Unrecognised encodings yield ADD with only the illegal flag set.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl       = '0;
    ctrl.aluop = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        casez (funct)
          6'b10000?: ctrl.aluop = ALU_ADD;
          6'b10001?: ctrl.aluop = ALU_SUB;
          FN_AND:    ctrl.aluop = ALU_AND;
          FN_OR:     ctrl.aluop = ALU_OR;
          FN_XOR:    ctrl.aluop = ALU_XOR;
          FN_NOR:    ctrl.aluop = ALU_NOR;
          FN_SLT:    ctrl.aluop = ALU_SLT;
          FN_SLTU:   ctrl.aluop = ALU_SLTU;
          FN_SLL: begin
            ctrl.aluop     = ALU_SLL;
            ctrl.use_shamt = 1'b1;
          end
          FN_SRL: begin
            ctrl.aluop     = ALU_SRL;
            ctrl.use_shamt = 1'b1;
          end
          FN_SRA: begin
            ctrl.aluop     = ALU_SRA;
            ctrl.use_shamt = 1'b1;
          end
          6'b01100?: begin
            ctrl.aluop = ALU_MULT;
            ctrl.multi = 1'b1;
          end
          6'b01101?: begin
            ctrl.aluop = ALU_DIV;
            ctrl.multi = 1'b1;
          end
          default:   ctrl.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        ctrl.aluop   = ALU_ADD;
        ctrl.use_imm = 1'b1;
      end
      OP_SLTI: begin
        ctrl.aluop   = ALU_SLT;
        ctrl.use_imm = 1'b1;
      end
      OP_SLTIU: begin
        ctrl.aluop   = ALU_SLTU;
        ctrl.use_imm = 1'b1;
      end
      // Logical immediates and LUI treat the immediate as unsigned.
      OP_ANDI: begin
        ctrl.aluop    = ALU_AND;
        ctrl.use_imm  = 1'b1;
        ctrl.imm_zext = 1'b1;
      end
      OP_ORI: begin
        ctrl.aluop    = ALU_OR;
        ctrl.use_imm  = 1'b1;
        ctrl.imm_zext = 1'b1;
      end
      OP_XORI: begin
        ctrl.aluop    = ALU_XOR;
        ctrl.use_imm  = 1'b1;
        ctrl.imm_zext = 1'b1;
      end
      OP_LUI: begin
        ctrl.aluop    = ALU_LUI;
        ctrl.use_imm  = 1'b1;
        ctrl.imm_zext = 1'b1;
      end
      OP_BEQ, OP_BNE: ctrl.aluop = ALU_SUB;
      default:        ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// ID->EX issue stage for the aluop bus: one-deep registered control word with
// valid/ready handshake, flush, and a busy window after MULT/DIV hand-off.
module alu_ctrl_issue
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] aluop,
  output logic       use_imm,
  output logic       imm_zext,
  output logic       use_shamt,
  output logic       multi,
  output logic       illegal,
  output logic       busy
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  ctrl_t          ctrl_dec;
  ctrl_t          ctrl_reg;
  state_t         state_reg;
  logic [CW-1:0]  cnt_reg;
  logic           out_valid_reg;
  logic           busy_reg;
  logic           accept;
  logic           handoff;

  alu_op_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .ctrl   (ctrl_dec)
  );

  // A multi op leaving the register sends us straight into BUSY, so nothing
  // new may be accepted in that same cycle.
  assign in_ready = ~reset & (state_reg == ST_IDLE)
                  & (~out_valid_reg | (out_ready & ~ctrl_reg.multi));
  assign accept   = in_valid & in_ready;
  assign handoff  = out_valid_reg & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      ctrl_reg      <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (flush) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            ctrl_reg      <= ctrl_dec;
            out_valid_reg <= 1'b1;
          end else if (handoff) begin
            out_valid_reg <= 1'b0;
          end
          if (handoff && ctrl_reg.multi) begin
            state_reg <= ST_BUSY;
            busy_reg  <= 1'b1;
            cnt_reg   <= (ctrl_reg.aluop == ALU_DIV) ? CW'(DIV_CYCLES - 1)
                                                     : CW'(MUL_CYCLES - 1);
          end
        end
        ST_BUSY: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign aluop     = ctrl_reg.aluop;
  assign use_imm   = ctrl_reg.use_imm;
  assign imm_zext  = ctrl_reg.imm_zext;
  assign use_shamt = ctrl_reg.use_shamt;
  assign multi     = ctrl_reg.multi;
  assign illegal   = ctrl_reg.illegal;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Bench for alu_ctrl_issue: directed scenarios then random traffic, all checked
// against a transaction-level model (held word, valid flag, busy cycles left).
module tb_alu_ctrl_issue;

  localparam int MULC = 4;
  localparam int DIVC = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] aluop;
  logic       use_imm, imm_zext, use_shamt, multi, illegal, busy;

  alu_ctrl_issue #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct     (funct),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .aluop     (aluop),
    .use_imm   (use_imm),
    .imm_zext  (imm_zext),
    .use_shamt (use_shamt),
    .multi     (multi),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic       mv = 1'b0;
  int         busy_left = 0;
  logic [8:0] exp_word = '0;   // {aluop, use_imm, imm_zext, use_shamt, multi, illegal}
  int         n_dut_hs = 0;
  logic       last_busy;

  // Expected decode from the instruction tables, using plain decimal codes.
  function automatic logic [8:0] ref_decode(input int op, input int fn);
    int a;
    logic imm, z, sh, mu, il;
    a = 0; imm = 0; z = 0; sh = 0; mu = 0; il = 0;
    if (op == 0) begin
      case (fn)
        32, 33: a = 0;
        34, 35: a = 1;
        36: a = 4;
        37: a = 5;
        38: a = 6;
        39: a = 7;
        42: a = 2;
        43: a = 3;
        0:  begin a = 8;  sh = 1; end
        2:  begin a = 9;  sh = 1; end
        3:  begin a = 10; sh = 1; end
        24, 25: begin a = 12; mu = 1; end
        26, 27: begin a = 13; mu = 1; end
        default: il = 1;
      endcase
    end else begin
      case (op)
        8, 9, 35, 43: begin a = 0; imm = 1; end
        10: begin a = 2; imm = 1; end
        11: begin a = 3; imm = 1; end
        12: begin a = 4;  imm = 1; z = 1; end
        13: begin a = 5;  imm = 1; z = 1; end
        14: begin a = 6;  imm = 1; z = 1; end
        15: begin a = 11; imm = 1; z = 1; end
        4, 5: a = 1;
        default: il = 1;
      endcase
    end
    return {a[3:0], imm, z, sh, mu, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check outputs, then advance
  // the model by what the next rising edge should do.
  task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                      input logic ordy, input logic fl);
    logic exp_rdy, hs, acc;
    @(negedge clk);
    in_valid = v; opcode = op; funct = fn; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = (busy_left == 0) && (!mv || (ordy && !exp_word[1]));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(mv));
    chk("busy", 32'(busy), 32'(busy_left > 0));
    if (mv)
      chk("fields", 32'({aluop, use_imm, imm_zext, use_shamt, multi, illegal}), 32'(exp_word));
    last_busy = busy;
    if (out_valid && out_ready) n_dut_hs++;
    hs  = mv && ordy;
    acc = v && exp_rdy;
    if (fl) begin
      mv = 1'b0;
      busy_left = 0;
    end else begin
      if (busy_left > 0) busy_left--;
      if (hs && exp_word[1]) busy_left = (exp_word[8:5] == 4'd13) ? DIVC : MULC;
      if (acc) begin
        exp_word = ref_decode(int'(op), int'(fn));
        mv = 1'b1;
      end else if (hs) begin
        mv = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_in_ready2", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fields", 32'({aluop, use_imm, imm_zext, use_shamt, multi, illegal}), 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    mv = 1'b0; busy_left = 0; exp_word = '0;
  endtask

  initial begin
    int hs0, bc, r;
    int ops[12] = '{8, 9, 10, 11, 12, 13, 14, 15, 35, 43, 4, 5};
    int fns[8]  = '{32, 34, 36, 39, 0, 3, 24, 26};
    logic [5:0] rop, rfn;

    do_reset();

    // NOR R-type
    step(1, 6'd0, 6'b100111, 1, 0);
    step(0, 6'd0, 6'd0, 1, 0);
    chk("t1_aluop", 32'(aluop), 32'b0111);
    chk("t1_use_imm", 32'(use_imm), 32'd0);

    // ORI then ADDI
    step(1, 6'b001101, 6'd0, 1, 0);
    step(1, 6'b001000, 6'd0, 1, 0);
    step(0, 6'd0, 6'd0, 1, 0);
    chk("t2_addi_zext", 32'(imm_zext), 32'd0);

    // Held output under back-pressure, then exactly one hand-off
    hs0 = n_dut_hs;
    step(1, 6'd0, 6'b100100, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 6'd0, 6'b100101, 0, 0);
    step(0, 6'd0, 6'd0, 1, 0);
    step(0, 6'd0, 6'd0, 1, 0);
    chk("t3_handoffs", 32'(n_dut_hs - hs0), 32'd1);

    // MULT busy window
    step(1, 6'd0, 6'b011000, 1, 0);
    step(1, 6'd0, 6'b100000, 1, 0);
    bc = 0;
    for (int i = 0; i < 7; i++) begin
      step(1, 6'd0, 6'b100000, 1, 0);
      if (last_busy) bc++;
    end
    chk("t4_mult_busy_len", 32'(bc), 32'(MULC));
    step(0, 6'd0, 6'd0, 1, 0);

    // Flush partway through a DIV window (counter at 20)
    step(1, 6'd0, 6'b011010, 1, 0);
    step(0, 6'd0, 6'd0, 1, 0);
    for (int i = 0; i < 11; i++) step(0, 6'd0, 6'd0, 1, 0);
    step(1, 6'd8, 6'd0, 1, 1);
    step(0, 6'd0, 6'd0, 1, 0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);

    // Flush discards a same-cycle accept; flush on multi hand-off starts no window
    step(1, 6'd0, 6'b100010, 1, 1);
    step(1, 6'd0, 6'b011001, 1, 0);
    step(0, 6'd0, 6'd0, 1, 1);
    step(0, 6'd0, 6'd0, 1, 0);
    chk("flush_mult_busy", 32'(busy), 32'd0);

    // Illegal opcode and full R-type funct sweep
    step(1, 6'b111111, 6'd0, 1, 0);
    step(0, 6'd0, 6'd0, 1, 0);
    chk("t6_illegal", 32'(illegal), 32'd1);
    chk("t6_aluop", 32'(aluop), 32'd0);
    for (int f = 0; f < 64; f++) begin
      step(1, 6'd0, 6'(f), 1, 0);
      while (busy_left > 0 || (mv && exp_word[1])) step(0, 6'd0, 6'd0, 1, 0);
    end
    step(0, 6'd0, 6'd0, 1, 0);

    // Reset in the middle of a DIV window
    step(1, 6'd0, 6'b011011, 1, 0);
    step(0, 6'd0, 6'd0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 6'd0, 6'd0, 1, 0);
    do_reset();
    step(0, 6'd0, 6'd0, 1, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        rop = 6'd0;
        rfn = ($urandom_range(0, 1) == 0) ? 6'(fns[$urandom_range(0, 7)]) : 6'($urandom_range(0, 63));
      end else if (r < 9) begin
        rop = 6'(ops[$urandom_range(0, 11)]);
        rfn = 6'($urandom_range(0, 63));
      end else begin
        rop = 6'($urandom_range(0, 63));
        rfn = 6'($urandom_range(0, 63));
      end
      step(1'($urandom_range(0, 3) != 0), rop, rfn,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0));
    end
    step(0, 6'd0, 6'd0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
